// File: rtl/gaussian_blur_seq_pkg.sv
// Shared types and kernel-radius helpers for the Gaussian pyramid row sequencer.
package gb_pkg;

  localparam int RADIUS_W   = 4;
  localparam int MAX_SCALES = 16;
  localparam int RADII_W    = RADIUS_W * MAX_SCALES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_SHIFT,
    ST_COMPUTE,
    ST_WRITE,
    ST_DONE
  } gb_state_e;

  typedef logic [RADIUS_W-1:0] radius_t;
  typedef logic [RADII_W-1:0]  radii_vec_t;

  // Unpack the radius of scale k from a packed radius vector (scale 0 in LSBs).
  function automatic radius_t radius_get(input radii_vec_t radii, input int k);
    return radii[k*RADIUS_W +: RADIUS_W];
  endfunction

  // Pack radius r into slot k of a radius vector, leaving other slots untouched.
  function automatic radii_vec_t radius_set(input radii_vec_t radii, input int k, input radius_t r);
    radii_vec_t v;
    v = radii;
    v[k*RADIUS_W +: RADIUS_W] = r;
    return v;
  endfunction

  // Largest radius among the first n scales; sets how many zero rows pad the frame.
  function automatic int radius_max(input radii_vec_t radii, input int n);
    int m;
    m = 0;
    for (int k = 0; k < n; k++) begin
      if (int'(radius_get(radii, k)) > m) begin
        m = int'(radius_get(radii, k));
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/gaussian_blur_seq_if.sv
// Control/address bundle between the row sequencer and its SRAMs, line buffer and datapath.
// The master side is the sequencer; the slave side is whatever drives start/abort/stall.
interface gaussian_blur_seq_if #(
  parameter int ADDR_W     = 9,
  parameter int NUM_SCALES = 4,
  parameter int PH_W       = 3
);
  logic                         start;
  logic                         abort;
  logic                         wr_stall;
  logic                         busy;
  logic                         done;
  logic                         img_re;
  logic [ADDR_W-1:0]            img_addr;
  logic                         lb_clear;
  logic                         buffer_we;
  logic                         fill_zero;
  logic [PH_W-1:0]              phase;
  logic                         phase_vld;
  logic [NUM_SCALES-1:0]        blur_we;
  logic [NUM_SCALES*ADDR_W-1:0] blur_addr;

  modport master (
    input  start, abort, wr_stall,
    output busy, done, img_re, img_addr, lb_clear, buffer_we, fill_zero,
           phase, phase_vld, blur_we, blur_addr
  );

  modport slave (
    output start, abort, wr_stall,
    input  busy, done, img_re, img_addr, lb_clear, buffer_we, fill_zero,
           phase, phase_vld, blur_we, blur_addr
  );
endinterface

// File: rtl/gaussian_blur_seq_scale_wr_gen.sv
// Per-scale write generator: maps the current input row to the centred output row
// of one blur scale and enables the write only when that centre lies inside the image.
module gb_scale_wr_gen
  import gb_pkg::*;
#(
  parameter int ROWS   = 480,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 9
) (
  input  logic [CNT_W-1:0]  i_in_row,
  input  logic              i_wr_state,
  input  radius_t           i_radius,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr
);

  // Signed width large enough for both the row counter and the radius plus a sign bit,
  // so rows past the image end never wrap back into the valid address range.
  localparam int C_W = ((CNT_W > RADIUS_W) ? CNT_W : RADIUS_W) + 1;
  localparam logic signed [C_W-1:0] LAST_C = C_W'(ROWS - 1);

  logic signed [C_W-1:0] w_centre;
  logic                  w_in_range;

  assign w_centre   = $signed({{(C_W-CNT_W){1'b0}}, i_in_row})
                    - $signed({{(C_W-RADIUS_W){1'b0}}, i_radius});
  assign w_in_range = (w_centre >= $signed(C_W'(0))) && (w_centre <= LAST_C);

  // Write enable and address are only meaningful while the sequencer is in WRITE.
  always_comb begin
    o_we   = 1'b0;
    o_addr = '0;
    if (i_wr_state && w_in_range) begin
      o_we   = 1'b1;
      o_addr = w_centre[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/gaussian_blur_seq.sv
// Row sequencer for one Gaussian pyramid stage: streams image rows (plus zero padding
// rows) into the line buffer, runs the blur datapath phases, and writes each scale's
// centred output row. All outputs are registered from the next-state decode.
module gaussian_blur_seq
  import gb_pkg::*;
#(
  parameter int                              ROWS       = 480,
  parameter int                              ADDR_W     = $clog2(ROWS),
  parameter int                              NUM_SCALES = 4,
  parameter logic [NUM_SCALES*RADIUS_W-1:0]  RADII      = 16'h3221,
  parameter int                              PIPE_LAT   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gaussian_blur_seq_if.master  bus
);

  localparam radii_vec_t RADII_EXT = RADII_W'(RADII);
  localparam int         MAXR      = radius_max(RADII_EXT, NUM_SCALES);
  localparam int         PH_W      = $clog2(PIPE_LAT);
  // in_row runs up to ROWS+MAXR-1, which can exceed the SRAM address range.
  localparam int         CNT_W     = $clog2(ROWS + MAXR + 1);

  localparam logic [CNT_W-1:0] ROWS_C   = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS + MAXR - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PIPE_LAT - 1);

  gb_state_e                    r_state, w_state_next;
  logic [CNT_W-1:0]             r_in_row, w_in_row_next;
  logic [PH_W-1:0]              r_phase, w_phase_next;

  logic                         r_busy, w_busy;
  logic                         r_done, w_done;
  logic                         r_img_re, w_img_re;
  logic [ADDR_W-1:0]            r_img_addr, w_img_addr;
  logic                         r_lb_clear, w_lb_clear;
  logic                         r_buffer_we, w_buffer_we;
  logic                         r_fill_zero, w_fill_zero;
  logic                         r_phase_vld, w_phase_vld;
  logic [NUM_SCALES-1:0]        r_blur_we, w_blur_we;
  logic [NUM_SCALES*ADDR_W-1:0] r_blur_addr, w_blur_addr;
  logic                         w_wr_state;

  // Next-state, row counter, phase counter and next-cycle output decode.
  always_comb begin
    w_state_next  = r_state;
    w_in_row_next = r_in_row;
    w_phase_next  = '0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_state_next = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (r_phase == PH_LAST) begin
          w_state_next = ST_WRITE;
        end else begin
          w_phase_next = r_phase + PH_W'(1);
        end
      end
      ST_WRITE: begin
        if (!bus.wr_stall) begin
          if (r_in_row == LAST_ROW) begin
            w_state_next = ST_DONE;
          end else begin
            w_in_row_next = r_in_row + CNT_W'(1);
            w_state_next  = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_state_next == ST_CLEAR) begin
      w_in_row_next = '0;
    end

    // Abort wins over everything, including a start seen in the same IDLE cycle.
    if (bus.abort) begin
      w_state_next  = ST_IDLE;
      w_in_row_next = '0;
      w_phase_next  = '0;
    end

    w_busy      = (w_state_next != ST_IDLE);
    w_done      = (w_state_next == ST_DONE);
    w_lb_clear  = (w_state_next == ST_CLEAR);
    w_img_re    = (w_state_next == ST_FETCH) && (w_in_row_next < ROWS_C);
    w_img_addr  = w_img_re ? w_in_row_next[ADDR_W-1:0] : '0;
    w_buffer_we = (w_state_next == ST_SHIFT);
    w_fill_zero = (w_state_next == ST_SHIFT) && (w_in_row_next >= ROWS_C);
    w_phase_vld = (w_state_next == ST_COMPUTE);
    w_wr_state  = (w_state_next == ST_WRITE);
  end

  // One write generator per scale; each sees the row that will be current next cycle.
  for (genvar gi = 0; gi < NUM_SCALES; gi++) begin : g_scale
    localparam radius_t RAD = radius_get(RADII_EXT, gi);

    gb_scale_wr_gen #(
      .ROWS   (ROWS),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_wr_gen (
      .i_in_row   (w_in_row_next),
      .i_wr_state (w_wr_state),
      .i_radius   (RAD),
      .o_we       (w_blur_we[gi]),
      .o_addr     (w_blur_addr[gi*ADDR_W +: ADDR_W])
    );
  end

  // State, counters and registered outputs; reset clears everything to IDLE/zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_row    <= '0;
      r_phase     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_img_re    <= 1'b0;
      r_img_addr  <= '0;
      r_lb_clear  <= 1'b0;
      r_buffer_we <= 1'b0;
      r_fill_zero <= 1'b0;
      r_phase_vld <= 1'b0;
      r_blur_we   <= '0;
      r_blur_addr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_in_row    <= w_in_row_next;
      r_phase     <= w_phase_next;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_img_re    <= w_img_re;
      r_img_addr  <= w_img_addr;
      r_lb_clear  <= w_lb_clear;
      r_buffer_we <= w_buffer_we;
      r_fill_zero <= w_fill_zero;
      r_phase_vld <= w_phase_vld;
      r_blur_we   <= w_blur_we;
      r_blur_addr <= w_blur_addr;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.img_re    = r_img_re;
  assign bus.img_addr  = r_img_addr;
  assign bus.lb_clear  = r_lb_clear;
  assign bus.buffer_we = r_buffer_we;
  assign bus.fill_zero = r_fill_zero;
  assign bus.phase     = r_phase;
  assign bus.phase_vld = r_phase_vld;
  assign bus.blur_we   = r_blur_we;
  assign bus.blur_addr = r_blur_addr;

endmodule

// File: tb/tb_gaussian_blur_seq.sv
// Bench for gaussian_blur_seq: frame-level vector table plus scoreboard of expected
// line-buffer shifts, image reads and per-scale SRAM writes; hand sequences for
// abort/start collision, mid-frame reset and a two-scale configuration.
`timescale 1ns/1ps
module tb_gaussian_blur_seq;
  import gb_pkg::*;

  localparam int ROWS     = 8;
  localparam int PIPE_LAT = 2;
  localparam int NS       = 4;
  localparam int AW       = 3;
  localparam int PHW      = 1;
  localparam int MAXR     = 3;
  localparam int ROW_CYC  = PIPE_LAT + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gaussian_blur_seq_if #(.ADDR_W(AW), .NUM_SCALES(NS), .PH_W(PHW)) bus ();
  gaussian_blur_seq_if #(.ADDR_W(AW), .NUM_SCALES(2), .PH_W(PHW)) bus2 ();

  gaussian_blur_seq #(
    .ROWS(ROWS), .ADDR_W(AW), .NUM_SCALES(NS), .RADII(16'h3221), .PIPE_LAT(PIPE_LAT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  gaussian_blur_seq #(
    .ROWS(ROWS), .ADDR_W(AW), .NUM_SCALES(2), .RADII(8'h21), .PIPE_LAT(PIPE_LAT)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int scale;
    int addr;
    int cyc;
  } wr_rec_t;

  typedef struct {
    int stall_row;
    int stall_len;
    int abort_cyc;
    int restart_cyc;
    int exp_done;
    int exp_shift;
    int exp_zero;
    int exp_phase;
  } frame_vec_t;

  wr_rec_t q_wr[$];
  int      q_img[$];
  bit      q_fz[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rad(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [NS-1:0] exp_we(input int row);
    logic [NS-1:0] v;
    v = '0;
    for (int k = 0; k < NS; k++) begin
      if (row >= rad(k) && row - rad(k) <= ROWS - 1) v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [NS*AW-1:0] exp_addr(input int row);
    logic [NS*AW-1:0] v;
    v = '0;
    for (int k = 0; k < NS; k++) begin
      if (row >= rad(k) && row - rad(k) <= ROWS - 1) v[k*AW +: AW] = AW'(row - rad(k));
    end
    return v;
  endfunction

  task automatic check_zero(input string name);
    check(name, {bus.busy, bus.done, bus.img_re, bus.img_addr, bus.lb_clear, bus.buffer_we,
                 bus.fill_zero, bus.phase, bus.phase_vld, bus.blur_we, bus.blur_addr}, 64'd0);
  endtask

  task automatic run_frame(input frame_vec_t v, output int done_cyc, output int n_shift,
                           output int n_zero, output int n_phase, output int busy_low);
    int cyc, stall_cyc, sh, ph_exp, post, post_done, post_busy;
    wr_rec_t rec;
    q_wr.delete();
    q_img.delete();
    q_fz.delete();
    stall_cyc = (v.stall_row >= 0) ? 1 + ROW_CYC * (v.stall_row + 1) : -1;
    // Scoreboard: everything the frame should produce, pushed as the frame is launched.
    for (int row = 0; row < ROWS + MAXR; row++) begin
      sh = (v.stall_row >= 0 && row >= v.stall_row) ? v.stall_len : 0;
      if (row < ROWS) q_img.push_back(row);
      q_fz.push_back(row >= ROWS);
      for (int k = 0; k < NS; k++) begin
        if (row >= rad(k) && row - rad(k) <= ROWS - 1)
          q_wr.push_back('{k, row - rad(k), 1 + ROW_CYC * (row + 1) + sh});
      end
    end
    done_cyc = 0; n_shift = 0; n_zero = 0; n_phase = 0; busy_low = 0; ph_exp = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (cyc <= 100) begin
      bus.wr_stall = (stall_cyc > 0 && cyc >= stall_cyc && cyc < stall_cyc + v.stall_len);
      bus.abort    = (cyc == v.abort_cyc);
      bus.start    = (cyc == v.restart_cyc);
      if (v.abort_cyc > 0 && cyc == v.abort_cyc + 1) begin
        check_zero("abort_outputs_zero");
        break;
      end
      if (cyc == 1) check("lb_clear_first_cycle", bus.lb_clear, 1);
      if (!bus.busy) busy_low++;
      if (bus.fill_zero) n_zero++;
      if (bus.buffer_we) begin
        n_shift++;
        check("shift_expected", q_fz.size() > 0, 1);
        if (q_fz.size() > 0) check("fill_zero", bus.fill_zero, q_fz.pop_front());
      end
      if (bus.img_re) begin
        check("img_read_expected", q_img.size() > 0, 1);
        if (q_img.size() > 0) check("img_addr", bus.img_addr, q_img.pop_front());
      end
      if (bus.phase_vld) begin
        n_phase++;
        check("phase", bus.phase, ph_exp);
        ph_exp = (ph_exp + 1) % PIPE_LAT;
      end else begin
        ph_exp = 0;
      end
      for (int k = 0; k < NS; k++) begin
        if (bus.blur_we[k] && !bus.wr_stall) begin
          check("write_expected", q_wr.size() > 0, 1);
          if (q_wr.size() > 0) begin
            rec = q_wr.pop_front();
            check("write_scale", k, rec.scale);
            check("write_addr", bus.blur_addr[k*AW +: AW], rec.addr);
            check("write_cycle", cyc, rec.cyc);
          end
        end
      end
      if (stall_cyc > 0 && cyc >= stall_cyc && cyc <= stall_cyc + v.stall_len) begin
        check("stall_hold_we", bus.blur_we, exp_we(v.stall_row));
        check("stall_hold_addr", bus.blur_addr, exp_addr(v.stall_row));
      end
      if (bus.done && done_cyc == 0) done_cyc = cyc;
      if (done_cyc != 0) break;
      @(posedge clk); #1;
      cyc++;
    end
    bus.wr_stall = 1'b0;
    bus.abort    = 1'b0;
    bus.start    = 1'b0;
    if (v.abort_cyc < 0) begin
      check("wr_queue_drained", q_wr.size(), 0);
      check("img_queue_drained", q_img.size(), 0);
      check("shift_queue_drained", q_fz.size(), 0);
    end
    // After the frame ends (or is aborted) the sequencer must sit idle with no done.
    post = (v.abort_cyc > 0) ? 45 : 2;
    post_done = 0;
    post_busy = 0;
    repeat (post) begin
      @(posedge clk); #1;
      if (bus.done) post_done++;
      if (bus.busy) post_busy++;
    end
    check("post_frame_done", post_done, 0);
    check("post_frame_busy", post_busy, 0);
  endtask

  frame_vec_t vec[4];
  int done_cyc, n_shift, n_zero, n_phase, busy_low;
  int cyc, done2, sh2, z2, wr2, bz;

  initial begin
    vec[0] = '{-1, 0, -1, -1, 57, 11, 3, 22};
    vec[1] = '{ 3, 5, -1, -1, 62, 11, 3, 22};
    vec[2] = '{-1, 0, 20, -1,  0,  4, 0,  8};
    vec[3] = '{-1, 0, -1, 30, 57, 11, 3, 22};

    bus.start = 1'b0;  bus.abort = 1'b0;  bus.wr_stall = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.wr_stall = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_outputs_zero");
    check("reset_dut2_busy", bus2.busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_frame(vec[i], done_cyc, n_shift, n_zero, n_phase, busy_low);
      $display("frame %0d: done_cyc=%0d shifts=%0d zero_shifts=%0d phases=%0d busy_low=%0d",
               i, done_cyc, n_shift, n_zero, n_phase, busy_low);
      check("done_cycle", done_cyc, vec[i].exp_done);
      check("shift_count", n_shift, vec[i].exp_shift);
      check("zero_shift_count", n_zero, vec[i].exp_zero);
      check("phase_count", n_phase, vec[i].exp_phase);
      check("busy_low_in_frame", busy_low, 0);
    end

    // Abort and start together in IDLE: stay idle.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_idle", bus.busy, 0);
    @(posedge clk); #1;
    check("abort_start_idle_after", bus.busy, 0);
    $display("abort+start in IDLE: busy=%0d", bus.busy);

    // Reset asserted during COMPUTE of row 0; start held high under reset is ignored.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_test_in_compute", {bus.phase_vld, bus.phase}, 2'b10);
    rst_n = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    check_zero("rst_midframe_outputs_zero");
    bz = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.busy) bz++;
    end
    check("start_ignored_in_reset", bz, 0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset_release", bus.busy, 0);
    $display("mid-frame reset: busy cycles under reset=%0d", bz);
    run_frame(vec[0], done_cyc, n_shift, n_zero, n_phase, busy_low);
    $display("frame after reset: done_cyc=%0d shifts=%0d", done_cyc, n_shift);
    check("done_cycle_after_reset", done_cyc, 57);
    check("shift_count_after_reset", n_shift, 11);

    // Two-scale configuration, radii {2,1}: two zero rows, ten shifts, 16 writes.
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    cyc = 1; done2 = 0; sh2 = 0; z2 = 0; wr2 = 0;
    while (cyc <= 100 && done2 == 0) begin
      if (bus2.buffer_we) sh2++;
      if (bus2.fill_zero) z2++;
      for (int k = 0; k < 2; k++) if (bus2.blur_we[k]) wr2++;
      if (bus2.done) done2 = cyc;
      if (done2 == 0) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    $display("two-scale frame: done_cyc=%0d shifts=%0d zero_shifts=%0d writes=%0d",
             done2, sh2, z2, wr2);
    check("cfg2_done_cycle", done2, 52);
    check("cfg2_shift_count", sh2, 10);
    check("cfg2_zero_shifts", z2, 2);
    check("cfg2_write_count", wr2, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
